// File: rtl/set_ctrl.sv
// Sequencing controller for one 4-way set of the L1 data cache.
// Holds the set's tag/valid/dirty/LRU/data state and runs write-back and fill on the memory port.
module set_ctrl #(
   parameter int unsigned TAG_W = 24,
   parameter int unsigned WAYS  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [5:0]       req_offset,
   input  logic [1:0]       req_size,
   input  logic [63:0]      req_wdata,
   output logic             resp_valid,
   output logic             resp_hit,
   output logic             resp_err,
   output logic [63:0]      resp_data,
   output logic             mem_req_valid,
   input  logic             mem_req_ready,
   output logic             mem_req_write,
   output logic [TAG_W-1:0] mem_req_tag,
   output logic [511:0]     mem_wdata,
   input  logic             mem_resp_valid,
   input  logic [511:0]     mem_rdata,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
);

   typedef enum logic [2:0] {StIdle, StLookup, StWb, StFillReq, StFillWait, StResp} state_e;

   state_e           state_q, state_d;
   logic             wr_q;
   logic [TAG_W-1:0] tag_q;
   logic [5:0]       off_q;
   logic [1:0]       size_q;
   logic [63:0]      wdata_q;
   logic             first_q, hit_q, err_q;
   logic [63:0]      rdata_q;
   logic [1:0]       victim_q;
   logic [TAG_W-1:0] tags_q [WAYS];
   logic [WAYS-1:0]  valid_q, dirty_q;
   logic [1:0]       age_q [WAYS];
   logic [511:0]     data_q [WAYS];
   logic [31:0]      hits_q, miss_q;

   logic         oob, hit_any;
   logic [1:0]   hit_way, victim_d, acc_way;
   logic [63:0]  size_mask, load_data;
   logic [8:0]   bit_off;
   logic [511:0] st_mask, st_data, way_blk, shifted;
   logic         accept, first_hit, first_miss, store_hit, install, acc_en;

   assign oob = ({1'b0, off_q} + (7'd1 << size_q)) > 7'd64;

   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (valid_q[i] && tags_q[i] == tag_q) begin
            hit_any = 1'b1;
            hit_way = 2'(i);
         end
      end
   end

   // Oldest way is the fallback; the lowest invalid way overrides it.
   always_comb begin
      victim_d = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (age_q[i] == 2'd3) victim_d = 2'(i);
      end
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!valid_q[i]) victim_d = 2'(i);
      end
   end

   always_comb begin
      case (size_q)
         2'd0:    size_mask = 64'h0000_0000_0000_00FF;
         2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
      bit_off   = {off_q, 3'b000};
      st_mask   = {448'd0, size_mask} << bit_off;
      st_data   = {448'd0, wdata_q & size_mask} << bit_off;
      way_blk   = data_q[hit_way];
      shifted   = way_blk >> bit_off;
      load_data = shifted[63:0] & size_mask;
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      first_hit  = 1'b0;
      first_miss = 1'b0;
      store_hit  = 1'b0;
      install    = 1'b0;
      acc_en     = 1'b0;
      acc_way    = hit_way;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               accept  = 1'b1;
               state_d = StLookup;
            end
         end
         StLookup: begin
            if (oob) begin
               state_d = StResp;
            end else if (hit_any) begin
               acc_en    = 1'b1;
               store_hit = wr_q;
               first_hit = first_q;
               state_d   = StResp;
            end else begin
               first_miss = first_q;
               state_d    = dirty_q[victim_d] ? StWb : StFillReq;
            end
         end
         StWb:       if (mem_req_ready) state_d = StFillReq;
         StFillReq:  if (mem_req_ready) state_d = StFillWait;
         StFillWait: begin
            if (mem_resp_valid) begin
               install = 1'b1;
               acc_en  = 1'b1;
               acc_way = victim_q;
               state_d = StLookup;
            end
         end
         StResp:     state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         wr_q     <= 1'b0;
         tag_q    <= '0;
         off_q    <= '0;
         size_q   <= '0;
         wdata_q  <= '0;
         first_q  <= 1'b0;
         hit_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         victim_q <= '0;
         valid_q  <= '0;
         dirty_q  <= '0;
         hits_q   <= '0;
         miss_q   <= '0;
         for (int i = 0; i < WAYS; i++) begin
            tags_q[i] <= '0;
            age_q[i]  <= 2'(i);
         end
      end else begin
         state_q <= state_d;
         if (accept) begin
            wr_q    <= req_write;
            tag_q   <= req_tag;
            off_q   <= req_offset;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            first_q <= 1'b1;
            hit_q   <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= '0;
         end
         if (state_q == StLookup) begin
            first_q <= 1'b0;
            if (oob) begin
               err_q <= 1'b1;
               hit_q <= 1'b0;
            end else if (hit_any) begin
               if (!wr_q) rdata_q <= load_data;
               if (wr_q) dirty_q[hit_way] <= 1'b1;
            end else begin
               victim_q <= victim_d;
               if (first_q) hit_q <= 1'b0;
            end
         end
         if (install) begin
            tags_q[victim_q]  <= tag_q;
            valid_q[victim_q] <= 1'b1;
            dirty_q[victim_q] <= 1'b0;
         end
         if (acc_en) begin
            for (int i = 0; i < WAYS; i++) begin
               if (2'(i) == acc_way) age_q[i] <= 2'd0;
               else if (age_q[i] < age_q[acc_way]) age_q[i] <= age_q[i] + 2'd1;
            end
         end
         if (first_hit && hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
         if (first_miss && miss_q != 32'hFFFF_FFFF) miss_q <= miss_q + 32'd1;
      end
   end

   // Block data is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (install) data_q[victim_q] <= mem_rdata;
      else if (store_hit) data_q[hit_way] <= (way_blk & ~st_mask) | (st_data & st_mask);
   end

   always_comb begin
      req_ready     = (state_q == StIdle);
      resp_valid    = (state_q == StResp);
      resp_hit      = (state_q == StResp) && hit_q;
      resp_err      = (state_q == StResp) && err_q;
      resp_data     = (state_q == StResp) ? rdata_q : 64'd0;
      mem_req_valid = (state_q == StWb) || (state_q == StFillReq);
      mem_req_write = (state_q == StWb);
      mem_req_tag   = '0;
      mem_wdata     = '0;
      if (state_q == StWb) begin
         mem_req_tag = tags_q[victim_q];
         mem_wdata   = data_q[victim_q];
      end else if (state_q == StFillReq) begin
         mem_req_tag = tag_q;
      end
      hit_count  = hits_q;
      miss_count = miss_q;
   end

endmodule

// File: tb/tb_set_ctrl.sv
// Bench for set_ctrl: directed vector table, hand-written corner sequences and randomized
// traffic checked against a recency-list cache model with a simple memory responder.
module tb_set_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [23:0]  req_tag = '0;
   logic [5:0]   req_offset = '0;
   logic [1:0]   req_size = '0;
   logic [63:0]  req_wdata = '0;
   logic         resp_valid, resp_hit, resp_err;
   logic [63:0]  resp_data;
   logic         mem_req_valid, mem_req_ready, mem_req_write;
   logic [23:0]  mem_req_tag;
   logic [511:0] mem_wdata;
   logic         mem_resp_valid;
   logic [511:0] mem_rdata;
   logic [31:0]  hit_count, miss_count;

   set_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_tag(req_tag), .req_offset(req_offset), .req_size(req_size), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_err(resp_err), .resp_data(resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_req_tag(mem_req_tag), .mem_wdata(mem_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- memory world ----------------
   typedef struct packed {
      logic         wr;
      logic [23:0]  tag;
      logic [511:0] data;
   } txn_t;

   logic [511:0] mem [logic [23:0]];
   txn_t         log_q [$];
   int           stall_req  = 0;
   bit           hold_resp  = 1'b0;
   bit           force_resp = 1'b0;

   function automatic logic [511:0] blk_of(input logic [23:0] t);
      logic [511:0] b;
      if (mem.exists(t)) return mem[t];
      for (int i = 0; i < 16; i++) b[32*i +: 32] = {t[7:0], 8'(i), t[15:0]} ^ 32'h5A5A_0000;
      return b;
   endfunction

   initial begin
      int           stall_left;
      int           fill_dly;
      bit           in_txn;
      txn_t         cur;
      logic [511:0] fill_blk;
      stall_left = 0; fill_dly = 0; in_txn = 1'b0; cur = '0; fill_blk = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         mem_req_ready  = 1'b0;
         if (rst) begin
            fill_dly = 0;
            in_txn   = 1'b0;
         end else begin
            if (fill_dly > 0) begin
               fill_dly--;
               if (fill_dly == 0) begin
                  mem_resp_valid = 1'b1;
                  mem_rdata      = fill_blk;
               end
            end else if (force_resp) begin
               mem_resp_valid = 1'b1;
               mem_rdata      = {16{32'hBAD0_BAD0}};
               force_resp     = 1'b0;
            end
            if (mem_req_valid) begin
               if (!in_txn) begin
                  in_txn     = 1'b1;
                  stall_left = stall_req;
                  stall_req  = 0;
                  cur        = {mem_req_write, mem_req_tag, mem_wdata};
               end else begin
                  chk("stall_valid", mem_req_valid, 1'b1);
                  chk("stall_write", mem_req_write, cur.wr);
                  chk("stall_tag", mem_req_tag, cur.tag);
                  chk("stall_wdata", mem_wdata, cur.data);
               end
               if (stall_left > 0) begin
                  stall_left--;
               end else begin
                  mem_req_ready = 1'b1;
                  in_txn        = 1'b0;
                  log_q.push_back(cur);
                  if (cur.wr) mem[cur.tag] = cur.data;
                  else begin
                     fill_blk = blk_of(cur.tag);
                     if (!hold_resp) fill_dly = 2;
                  end
               end
            end
         end
      end
   end

   // ---------------- cache reference model ----------------
   logic [23:0]  m_tag [4];
   bit           m_val [4];
   bit           m_dirty [4];
   logic [511:0] m_dat [4];
   int           m_order [$];  // most recently used way first
   logic [31:0]  m_hits, m_miss;

   function automatic void model_reset();
      for (int i = 0; i < 4; i++) begin
         m_val[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_order = '{0, 1, 2, 3};
      m_hits = '0;
      m_miss = '0;
   endfunction

   function automatic void touch(input int w);
      int idx = 0;
      for (int i = 0; i < m_order.size(); i++) if (m_order[i] == w) idx = i;
      m_order.delete(idx);
      m_order.push_front(w);
   endfunction

   task automatic do_req(input bit wr, input logic [23:0] tag, input int off, input int sz,
                         input logic [63:0] wd, input int stall, output bit o_hit,
                         output bit o_err, output logic [63:0] o_data, output int o_lat);
      int          nb, w, v, e_lat;
      bit          e_err, e_hit;
      logic [63:0] e_data;
      txn_t        exp_q [$];
      nb = 1 << sz; w = -1; e_hit = 1'b0; e_data = '0; e_lat = 2;
      e_err = (off + nb) > 64;
      if (!e_err) begin
         for (int i = 0; i < 4; i++) if (m_val[i] && m_tag[i] == tag) w = i;
         if (w >= 0) begin
            e_hit = 1'b1;
            if (m_hits != 32'hFFFF_FFFF) m_hits++;
         end else begin
            if (m_miss != 32'hFFFF_FFFF) m_miss++;
            v = m_order[3];
            for (int i = 3; i >= 0; i--) if (!m_val[i]) v = i;
            e_lat = 6 + stall;
            if (m_dirty[v]) begin
               exp_q.push_back({1'b1, m_tag[v], m_dat[v]});
               e_lat++;
            end
            exp_q.push_back({1'b0, tag, 512'd0});
            m_dat[v] = blk_of(tag);
            m_tag[v] = tag;
            m_val[v] = 1'b1;
            m_dirty[v] = 1'b0;
            w = v;
         end
         touch(w);
         for (int b = 0; b < nb; b++) begin
            if (wr) m_dat[w][8*(off+b) +: 8] = wd[8*b +: 8];
            else e_data[8*b +: 8] = m_dat[w][8*(off+b) +: 8];
         end
         if (wr) m_dirty[w] = 1'b1;
      end
      log_q.delete();
      stall_req  = e_lat > 2 ? stall : 0;
      req_write  = wr;
      req_tag    = tag;
      req_offset = 6'(off);
      req_size   = 2'(sz);
      req_wdata  = wd;
      req_valid  = 1'b1;
      @(negedge clk);
      o_lat     = 1;
      req_valid = 1'b0;
      while (!resp_valid && o_lat < 200) begin
         @(negedge clk);
         o_lat++;
      end
      o_hit = resp_hit; o_err = resp_err; o_data = resp_data;
      chk("resp_valid", resp_valid, 1'b1);
      chk("resp_hit", resp_hit, e_hit);
      chk("resp_err", resp_err, e_err);
      chk("resp_data", resp_data, e_data);
      chk("latency", 32'(o_lat), 32'(e_lat));
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_miss);
      chk("mem_txn_count", 32'(log_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk("mem_txn_write", log_q[i].wr, exp_q[i].wr);
         chk("mem_txn_tag", log_q[i].tag, exp_q[i].tag);
         chk("mem_txn_data", log_q[i].data, exp_q[i].data);
      end
      @(negedge clk);
      chk("resp_one_cycle", resp_valid, 1'b0);
      chk("ready_after_resp", req_ready, 1'b1);
      stall_req = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   typedef struct {
      bit          wr;
      logic [23:0] tag;
      int          off;
      int          sz;
      logic [63:0] wd;
      bit          e_hit;
      bit          e_err;
      logic [63:0] e_data;
      int          e_lat;
      int          e_ntx;
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vt [8];
      bit          h, e;
      logic [63:0] d;
      int          lat, sz, nb, off, n;
      vt[0] = '{1'b1, 24'h15, 4,  2, 64'hDEAD_BEEF, 1'b0, 1'b0, 64'h0,         6, 1};
      vt[1] = '{1'b0, 24'h15, 4,  2, 64'h0,         1'b1, 1'b0, 64'hDEAD_BEEF, 2, 0};
      vt[2] = '{1'b0, 24'h15, 60, 3, 64'h0,         1'b0, 1'b1, 64'h0,         2, 0};
      vt[3] = '{1'b0, 24'h15, 5,  0, 64'h0,         1'b1, 1'b0, 64'hBE,        2, 0};
      vt[4] = '{1'b0, 24'h15, 4,  1, 64'h0,         1'b1, 1'b0, 64'hBEEF,      2, 0};
      vt[5] = '{1'b1, 24'h15, 63, 0, 64'h1234_56A5, 1'b1, 1'b0, 64'h0,         2, 0};
      vt[6] = '{1'b0, 24'h15, 63, 0, 64'h0,         1'b1, 1'b0, 64'hA5,        2, 0};
      vt[7] = '{1'b0, 24'h15, 61, 2, 64'h0,         1'b0, 1'b1, 64'h0,         2, 0};

      do_reset();
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_hit", resp_hit, 1'b0);
      chk("rst_resp_err", resp_err, 1'b0);
      chk("rst_resp_data", resp_data, 64'd0);
      chk("rst_mem_valid", mem_req_valid, 1'b0);
      chk("rst_mem_write", mem_req_write, 1'b0);
      chk("rst_mem_tag", mem_req_tag, 24'd0);
      chk("rst_mem_wdata", mem_wdata, 512'd0);
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);

      for (int i = 0; i < 8; i++) begin
         do_req(vt[i].wr, vt[i].tag, vt[i].off, vt[i].sz, vt[i].wd, 0, h, e, d, lat);
         chk($sformatf("tbl%0d_hit", i), h, vt[i].e_hit);
         chk($sformatf("tbl%0d_err", i), e, vt[i].e_err);
         chk($sformatf("tbl%0d_data", i), d, vt[i].e_data);
         chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(vt[i].e_lat));
         chk($sformatf("tbl%0d_ntx", i), 32'(log_q.size()), 32'(vt[i].e_ntx));
      end
      chk("tbl_hit_count", hit_count, 32'd5);
      chk("tbl_miss_count", miss_count, 32'd1);

      // LRU victim choice with no dirty lines
      do_reset();
      for (int t = 1; t <= 4; t++) do_req(1'b0, 24'(t), 0, 3, 64'h0, 0, h, e, d, lat);
      do_req(1'b0, 24'd1, 0, 3, 64'h0, 0, h, e, d, lat);
      do_req(1'b0, 24'd5, 0, 3, 64'h0, 0, h, e, d, lat);
      chk("lru_ntx", 32'(log_q.size()), 32'd1);
      if (log_q.size() > 0) begin
         chk("lru_fill_write", log_q[0].wr, 1'b0);
         chk("lru_fill_tag", log_q[0].tag, 24'd5);
      end
      do_req(1'b0, 24'd2, 0, 3, 64'h0, 0, h, e, d, lat);
      chk("lru_tag2_evicted", h, 1'b0);
      do_req(1'b0, 24'd1, 0, 3, 64'h0, 0, h, e, d, lat);
      chk("lru_tag1_kept", h, 1'b1);

      // Dirty eviction with write-back of the oldest line
      do_reset();
      for (int t = 1; t <= 4; t++) do_req(1'b1, 24'(t), 0, 0, 64'(8'h11 * t), 0, h, e, d, lat);
      for (int t = 2; t <= 4; t++) do_req(1'b0, 24'(t), 0, 0, 64'h0, 0, h, e, d, lat);
      do_req(1'b0, 24'd9, 0, 0, 64'h0, 0, h, e, d, lat);
      chk("wb_ntx", 32'(log_q.size()), 32'd2);
      chk("wb_lat", 32'(lat), 32'd7);
      if (log_q.size() == 2) begin
         chk("wb_write", log_q[0].wr, 1'b1);
         chk("wb_tag", log_q[0].tag, 24'd1);
         chk("wb_byte0", log_q[0].data[7:0], 8'h11);
         chk("wb_fill_tag", log_q[1].tag, 24'd9);
      end

      // Fill request held off by memory for five cycles
      do_reset();
      do_req(1'b0, 24'h20, 8, 2, 64'h0, 5, h, e, d, lat);
      chk("stall_lat", 32'(lat), 32'd11);

      // Reset while waiting for fill data, then stray fill data
      hold_resp = 1'b1;
      log_q.delete();
      req_write = 1'b0; req_tag = 24'h33; req_offset = '0; req_size = 2'd3; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (log_q.size() == 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort_fill_seen", 32'(log_q.size()), 32'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_mem_valid", mem_req_valid, 1'b0);
      chk("abort_req_ready", req_ready, 1'b1);
      chk("abort_resp_valid", resp_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      force_resp = 1'b1;
      repeat (3) @(negedge clk);
      hold_resp = 1'b0;
      model_reset();
      chk("abort_idle_ready", req_ready, 1'b1);
      do_req(1'b0, 24'h20, 8, 2, 64'h0, 0, h, e, d, lat);
      chk("abort_no_valid_left", h, 1'b0);
      do_req(1'b0, 24'h33, 0, 3, 64'h0, 0, h, e, d, lat);
      chk("abort_no_install", h, 1'b0);

      // Miss counter saturation
      force dut.miss_q = 32'hFFFF_FFFF;
      #1;
      release dut.miss_q;
      #1;
      m_miss = 32'hFFFF_FFFF;
      chk("sat_preset", miss_count, 32'hFFFF_FFFF);
      do_req(1'b0, 24'h44, 0, 0, 64'h0, 0, h, e, d, lat);
      chk("sat_hold", miss_count, 32'hFFFF_FFFF);

      // Randomized traffic over a small tag pool
      for (int k = 0; k < 200; k++) begin
         sz = int'($urandom_range(0, 3));
         nb = 1 << sz;
         if ($urandom_range(0, 9) == 0) off = int'($urandom_range(0, 63));
         else off = int'($urandom_range(0, 64 - nb));
         do_req(1'($urandom_range(0, 1)), 24'($urandom_range(1, 7)), off, sz,
                {$urandom, $urandom}, int'($urandom_range(0, 3)), h, e, d, lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
